// File: rtl/bnn_param_loader.sv
// bnn_param_loader
// Loads the serial weight/bias chain of a row of daisy-chained neurons and
// reads it back non-destructively.
//   LOAD : parameter bytes arrive on a valid/ready stream and are shifted
//          MSB-first into the chain, one bit per setup cycle, for exactly
//          CHAIN_BITS cycles. The low PAD bits of the last byte are dropped.
//   READ : the chain is recirculated (chain_in = chain_out) for CHAIN_BITS
//          cycles while the bits are collected into bytes on out_data.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start_load/start_read begin an operation (sampled in IDLE only)
//   in_data/valid/ready   parameter byte stream in
//   out_data/valid/ready  readback byte stream out (out_data registered)
//   setup, chain_in       chain shift enable and serial data to first neuron
//   chain_out             serial data from the last neuron
//   busy, loaded, done    status: not idle / full load since reset / finish pulse
module bnn_param_loader #(
   parameter int CHAIN_BITS = 44
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_load,
   input  logic       start_read,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       setup,
   output logic       chain_in,
   input  logic       chain_out,
   output logic       busy,
   output logic       loaded,
   output logic       done
);

   localparam int NBYTES = (CHAIN_BITS + 7) / 8;
   localparam int PAD    = 8 * NBYTES - CHAIN_BITS;
   localparam int CW     = $clog2(CHAIN_BITS + 1);
   localparam int BW     = $clog2(NBYTES + 1);

   localparam logic [CW-1:0] LAST_BIT  = CW'(CHAIN_BITS - 1);
   localparam logic [CW-1:0] FULL_CNT  = CW'(CHAIN_BITS);
   localparam logic [BW-1:0] LAST_BYTE = BW'(NBYTES - 1);
   localparam logic [BW-1:0] ALL_BYTES = BW'(NBYTES);
   localparam logic [3:0]    LAST_REM  = 4'(8 - PAD);

   typedef enum logic [1:0] {IDLE, LOAD, READ} state_t;

   state_t          state, state_nx;
   logic [7:0]      sbuf;       // load shift buffer, bit 7 drives the chain
   logic [3:0]      rem;        // bits still to shift out of sbuf
   logic [CW-1:0]   bit_cnt;    // chain shifts done in this operation
   logic [BW-1:0]   byte_cnt;   // bytes accepted in this load
   logic [7:0]      col;        // readback collector
   logic [3:0]      col_cnt;    // bits in collector
   logic            pend;       // col holds a finished byte waiting for out_data

   logic            out_free;
   logic            slot_free;
   logic            load_setup;
   logic            read_setup;
   logic            take;
   logic            finish;
   logic            complete;
   logic [7:0]      base_col;
   logic [7:0]      sh_col;
   logic [3:0]      sh_cnt;
   logic [7:0]      col_just;

   always_comb begin
      out_free   = !out_valid || out_ready;
      // a pending byte is moved to out_data this cycle whenever out_data frees,
      // so a byte completed now can only go straight out if nothing is pending
      slot_free  = out_free && !pend;
      load_setup = (state == LOAD) && (rem != 4'd0);
      read_setup = (state == READ) && (bit_cnt != FULL_CNT) && !(pend && !out_free);
      setup      = load_setup || read_setup;
      // byte_cnt gate keeps the last shift from swallowing a byte past the end
      in_ready   = (state == LOAD) && (byte_cnt != ALL_BYTES) &&
                   ((rem == 4'd0) || ((rem == 4'd1) && setup));
      take       = in_valid && in_ready;
      chain_in   = (state == LOAD) ? sbuf[7] : chain_out;
      busy       = (state != IDLE);

      base_col   = pend ? 8'd0 : col;
      sh_col     = {base_col[6:0], chain_out};
      sh_cnt     = col_cnt + 4'd1;
      complete   = (sh_cnt == 4'd8) || (bit_cnt == LAST_BIT);
      col_just   = sh_col << (4'd8 - sh_cnt);   // final short byte is left-justified

      finish     = 1'b0;
      state_nx   = state;
      case (state)
         IDLE: begin
            if (start_load)      state_nx = LOAD;
            else if (start_read) state_nx = READ;
         end
         LOAD: finish = setup && (bit_cnt == LAST_BIT);
         // READ ends once the last byte is in out_data: either it went there
         // on the final shift, or it was parked and is popped now
         READ: finish = (read_setup && (bit_cnt == LAST_BIT) && slot_free) ||
                        ((bit_cnt == FULL_CNT) && pend && out_free);
         default: state_nx = IDLE;
      endcase
      if (finish) state_nx = IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         sbuf      <= 8'd0;
         rem       <= 4'd0;
         bit_cnt   <= '0;
         byte_cnt  <= '0;
         col       <= 8'd0;
         col_cnt   <= 4'd0;
         pend      <= 1'b0;
         out_data  <= 8'd0;
         out_valid <= 1'b0;
         loaded    <= 1'b0;
         done      <= 1'b0;
      end else begin
         state <= state_nx;
         done  <= finish;

         case (state)
            IDLE: begin
               if (start_load) begin
                  loaded   <= 1'b0;
                  bit_cnt  <= '0;
                  byte_cnt <= '0;
                  rem      <= 4'd0;
               end else if (start_read) begin
                  bit_cnt  <= '0;
                  col_cnt  <= 4'd0;
               end
            end
            LOAD: begin
               if (take) begin
                  sbuf     <= in_data;
                  rem      <= (byte_cnt == LAST_BYTE) ? LAST_REM : 4'd8;
                  byte_cnt <= byte_cnt + BW'(1);
               end else if (setup) begin
                  sbuf <= {sbuf[6:0], 1'b0};
                  rem  <= rem - 4'd1;
               end
               if (setup)  bit_cnt <= bit_cnt + CW'(1);
               if (finish) loaded  <= 1'b1;
            end
            READ: begin
               if (read_setup) bit_cnt <= bit_cnt + CW'(1);
            end
            default: ;
         endcase

         // output register: pop a parked byte, or drop valid once taken
         if (pend && out_free) begin
            out_data  <= col;
            out_valid <= 1'b1;
            pend      <= 1'b0;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         if (read_setup) begin
            if (complete) begin
               col_cnt <= 4'd0;
               if (slot_free) begin
                  out_data  <= col_just;
                  out_valid <= 1'b1;
               end else begin
                  col  <= col_just;
                  pend <= 1'b1;
               end
            end else begin
               col     <= sh_col;
               col_cnt <= sh_cnt;
            end
         end
      end
   end

endmodule

// File: tb/tb_bnn_param_loader.sv
// Bench for bnn_param_loader: a 44-bit shift-register stands in for the
// neuron chain; expected chain contents and readback bytes come from the
// loaded byte list (MSB-first bit stream, first bit deepest, pad bits zero).
module tb_bnn_param_loader;
   localparam int CB = 44;
   localparam int NB = (CB + 7) / 8;
   localparam int PAD = 8 * NB - CB;

   logic       clk = 1'b0;
   logic       reset, start_load, start_read, in_valid, out_ready;
   logic [7:0] in_data;
   logic       in_ready, out_valid, setup, chain_in, chain_out, busy, loaded, done;
   logic [7:0] out_data;
   logic [CB-1:0] chain = '0;

   bnn_param_loader #(.CHAIN_BITS(CB)) dut (
      .clk(clk), .reset(reset), .start_load(start_load), .start_read(start_read),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .setup(setup), .chain_in(chain_in), .chain_out(chain_out),
      .busy(busy), .loaded(loaded), .done(done));

   always #5 clk = ~clk;

   // neuron chain stand-in: index CB-1 is the deepest position
   assign chain_out = chain[CB-1];
   always @(posedge clk) if (setup) chain <= {chain[CB-2:0], chain_in};

   int checks = 0, errors = 0;
   int setup_cnt = 0, done_cnt = 0, rd_taken = 0, stall_cnt = 0, cyc = 0;
   logic [7:0] sb[$];
   logic [7:0] cur[NB];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (setup) setup_cnt++;
      if (done) done_cnt++;
      if (busy && !setup) stall_cnt++;
      if (out_valid && out_ready) begin
         rd_taken++;
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL rd_extra: got %0h expected no byte", out_data);
         end else begin
            chk("rd_byte", 64'(out_data), 64'(sb.pop_front()));
         end
      end
   end

   task automatic check_chain(input string name);
      logic [CB-1:0] exp;
      for (int k = 0; k < CB; k++) exp[CB-1-k] = cur[k/8][7-(k%8)];
      chk(name, 64'(chain), 64'(exp));
   endtask

   // gap < 0: random 0..3 idle cycles after each byte has drained
   task automatic do_load(input int gap, input bit both, input bit mid_read, input bit chk_lat);
      bit hs; int n, g, c0;
      setup_cnt = 0; done_cnt = 0; stall_cnt = 0; c0 = 0;
      start_load = 1; start_read = both;
      @(posedge clk); #1;
      start_load = 0; start_read = 0;
      for (int i = 0; i < NB; i++) begin
         in_data = cur[i]; in_valid = 1; hs = 0; n = 0;
         while (!hs && n < 100) begin
            @(negedge clk);
            if (i == 0 && n == 0) begin
               c0 = cyc;
               chk("load_busy", 64'(busy), 64'd1);
               chk("load_in_ready", 64'(in_ready), 64'd1);
            end
            hs = in_ready; n++;
            @(posedge clk); #1;
            start_read = 0;
         end
         in_valid = 0;
         if (!hs) chk("load_handshake", 64'd0, 64'd1);
         if (mid_read && i == 2) start_read = 1;
         g = (gap < 0) ? int'($urandom_range(3, 0)) : gap;
         if (i < NB - 1 && g > 0) repeat (7 + g) begin @(posedge clk); #1; end
      end
      n = 0; hs = 0;
      while (!hs && n < 200) begin
         @(negedge clk); hs = done; n++;
      end
      chk("load_done_seen", 64'(hs), 64'd1);
      chk("load_done_busy", 64'(busy), 64'd0);
      if (chk_lat) chk("load_latency", 64'(cyc - c0), 64'(CB + 1));
      repeat (3) begin @(posedge clk); #1; end
      chk("load_setup_cnt", 64'(setup_cnt), 64'(CB));
      chk("load_done_cnt", 64'(done_cnt), 64'd1);
      chk("load_loaded", 64'(loaded), 64'd1);
      if (gap >= 0) chk("load_gap_cycles", 64'(stall_cnt), 64'(1 + gap * (NB - 1)));
      check_chain("load_chain");
   endtask

   // mode 0: out_ready high, 1: out_ready low 20 cycles after first byte, 2: random
   task automatic do_read(input int mode);
      int n, stall_left;
      for (int i = 0; i < NB; i++)
         sb.push_back((i == NB - 1) ? (cur[i] & 8'(8'hFF << PAD)) : cur[i]);
      setup_cnt = 0; done_cnt = 0; rd_taken = 0; stall_cnt = 0; stall_left = 20;
      out_ready = (mode == 2) ? 1'($urandom_range(1, 0)) : 1'b1;
      start_read = 1;
      @(posedge clk); #1;
      start_read = 0;
      @(negedge clk);
      chk("read_first_setup", 64'(setup), 64'd1);
      chk("read_busy", 64'(busy), 64'd1);
      n = 0;
      while (!(done_cnt > 0 && sb.size() == 0 && !out_valid) && n < 3000) begin
         @(posedge clk); #1; n++;
         case (mode)
            1: if (rd_taken > 0 && stall_left > 0) begin out_ready = 0; stall_left--; end
               else out_ready = 1;
            2: out_ready = 1'($urandom_range(1, 0));
            default: out_ready = 1;
         endcase
      end
      out_ready = 1;
      chk("read_finished", 64'(n < 3000), 64'd1);
      sb.delete();
      chk("read_setup_cnt", 64'(setup_cnt), 64'(CB));
      chk("read_done_cnt", 64'(done_cnt), 64'd1);
      chk("read_bytes", 64'(rd_taken), 64'(NB));
      if (mode == 0) chk("read_no_stall", 64'(stall_cnt), 64'd0);
      if (mode == 1) chk("read_stalled", 64'(stall_cnt > 0), 64'd1);
      check_chain("read_chain_kept");
   endtask

   initial begin
      bit hs; int sc, n, idx;
      reset = 1; start_load = 0; start_read = 0; in_valid = 0; in_data = 0; out_ready = 1;
      repeat (2) @(posedge clk);
      #1 reset = 0;
      @(negedge clk);
      chk("rst_setup", 64'(setup), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_loaded", 64'(loaded), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      @(posedge clk); #1;

      cur = '{8'hA5, 8'h3C, 8'hF0, 8'h0F, 8'h81, 8'h7E};
      do_load(0, 0, 0, 1);
      do_load(3, 0, 0, 0);
      do_read(0);
      do_read(1);

      // simultaneous starts, then a start_read in the middle of the load
      cur = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
      do_load(0, 1, 1, 0);
      repeat (10) begin @(posedge clk); #1; end
      chk("no_extra_shift", 64'(setup_cnt), 64'(CB));
      chk("idle_after_load", 64'(busy), 64'd0);

      // reset after 20 load shifts
      start_load = 1;
      @(posedge clk); #1;
      start_load = 0; idx = 0; in_data = cur[0]; in_valid = 1; sc = 0; n = 0;
      while (sc < 20 && n < 200) begin
         @(negedge clk);
         if (setup) sc++;
         hs = in_ready;
         @(posedge clk); #1; n++;
         if (hs && idx < NB - 1) begin idx++; in_data = cur[idx]; end
      end
      chk("mid_shifts", 64'(sc), 64'd20);
      reset = 1; in_valid = 0;
      @(posedge clk);
      @(negedge clk);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_setup", 64'(setup), 64'd0);
      chk("mid_rst_loaded", 64'(loaded), 64'd0);
      chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      reset = 0;
      @(posedge clk); #1;
      cur = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h55, 8'hAA};
      do_load(0, 0, 0, 0);
      do_read(0);

      // randomized loads and readbacks
      repeat (4) begin
         for (int i = 0; i < NB; i++) cur[i] = 8'($urandom);
         do_load(-1, 0, 0, 0);
         do_read(2);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
